// File: rtl/snitch_icache_lookup_sched.sv
// snitch_icache_lookup_sched: round-robin lookup port sharing with bounded in-flight lookups and flush sequencing
module snitch_icache_lookup_sched #(
  parameter int NR_REQ       = 2,
  parameter int FETCH_AW     = 32,
  parameter int ID_WIDTH     = 2,
  parameter int LINE_COUNT   = 128,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NR_REQ*FETCH_AW-1:0] req_addr_i,
  input  logic [NR_REQ-1:0]          req_valid_i,
  output logic [NR_REQ-1:0]          req_ready_o,
  output logic [FETCH_AW-1:0]        lookup_addr_o,
  output logic [ID_WIDTH-1:0]        lookup_id_o,
  output logic                       lookup_valid_o,
  input  logic                       lookup_ready_i,
  input  logic                       rsp_done_i,
  input  logic                       flush_req_i,
  output logic                       flush_valid_o,
  input  logic                       flush_ready_i,
  output logic                       busy_o
);
  localparam int PW = NR_REQ > 1 ? $clog2(NR_REQ) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = $clog2(LINE_COUNT + 1);
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, SWEEP} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] sweep_cnt;
  logic [IW-1:0] inflight;
  logic [PW-1:0] rr_ptr, lock_idx, sel, gnt, idx;
  logic lock, pend_flush, found, gnt_valid, hs, dec;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NR_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  // a stalled grant stays pinned until its handshake, overriding flush and the in-flight cap
  assign gnt = lock ? lock_idx : sel;
  assign gnt_valid = state_q == RUN && (lock || (!flush_req_i && inflight < IW'(MAX_INFLIGHT) && found));
  assign hs = gnt_valid && lookup_ready_i;
  assign dec = rsp_done_i && inflight != '0;
  assign lookup_valid_o = gnt_valid;
  assign lookup_addr_o = req_addr_i[gnt*FETCH_AW +: FETCH_AW];
  assign lookup_id_o = ID_WIDTH'(gnt);
  assign req_ready_o = hs ? NR_REQ'(1) << gnt : '0;
  assign flush_valid_o = state_q == FLUSH;
  assign busy_o = state_q != RUN;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (flush_req_i && !lock) state_d = DRAIN;
      DRAIN: if (inflight == '0) state_d = FLUSH;
      FLUSH: if (flush_ready_i) state_d = SWEEP;
      SWEEP: if (sweep_cnt == SW'(LINE_COUNT)) state_d = pend_flush ? DRAIN : RUN;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SWEEP;
      sweep_cnt <= '0;
      inflight <= '0;
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_idx <= '0;
      pend_flush <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_cnt <= (state_q == SWEEP && sweep_cnt != SW'(LINE_COUNT)) ? sweep_cnt + 1'b1 : '0;
      inflight <= inflight + IW'(hs) - IW'(dec);
      lock <= gnt_valid && !lookup_ready_i;
      lock_idx <= gnt;
      if (hs) rr_ptr <= (int'(gnt) == NR_REQ - 1) ? '0 : gnt + 1'b1;
      pend_flush <= (state_q == SWEEP && flush_req_i) || (pend_flush && !(state_q == FLUSH && flush_ready_i));
    end
  end
  assert property (@(posedge clk_i) disable iff (rst_i) !(rsp_done_i && inflight == '0));
  assert property (@(posedge clk_i) disable iff (rst_i) inflight <= IW'(MAX_INFLIGHT));
endmodule

// File: tb/tb_snitch_icache_lookup_sched.sv
// tb_snitch_icache_lookup_sched: directed checks of arbitration, grant lock, in-flight cap and flush sequencing
module tb_snitch_icache_lookup_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] req_addr;
  logic [1:0] req_valid, req_ready;
  logic [31:0] lookup_addr;
  logic [1:0] lookup_id;
  logic lookup_valid, lookup_ready, rsp_done, flush_req, flush_valid, flush_ready, busy;
  int checks = 0;
  int errors = 0;
  int n;
  logic seen, brk;
  snitch_icache_lookup_sched dut (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .lookup_addr_o(lookup_addr), .lookup_id_o(lookup_id), .lookup_valid_o(lookup_valid),
    .lookup_ready_i(lookup_ready), .rsp_done_i(rsp_done), .flush_req_i(flush_req),
    .flush_valid_o(flush_valid), .flush_ready_i(flush_ready), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    req_addr = '0; req_valid = '0; lookup_ready = 0; rsp_done = 0; flush_req = 0; flush_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_valid", lookup_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_flush_valid", flush_valid, 0);
    @(negedge clk);
    rst = 0;
    #1;
    n = 0; seen = 0;
    while (busy && n < 200) begin seen |= lookup_valid; n++; @(negedge clk); #1; end
    chk("reset_busy_len", n, 129);
    chk("reset_no_valid", seen, 0);
    req_addr = {32'hB000_0004, 32'hA000_0000}; req_valid = 2'b11; lookup_ready = 1;
    for (int i = 0; i < 4; i++) begin
      rsp_done = (i != 0);
      #1;
      chk("rr_valid", lookup_valid, 1);
      chk("rr_id", lookup_id, i % 2);
      chk("rr_addr", lookup_addr, (i % 2) ? 32'hB000_0004 : 32'hA000_0000);
      chk("rr_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    req_valid = 0; lookup_ready = 0; rsp_done = 1;
    #1 chk("rr_idle", lookup_valid, 0);
    @(negedge clk);
    rsp_done = 0;
    req_addr = {32'h0000_2000, 32'h0000_1000}; req_valid = 2'b01;
    #1;
    chk("lk0_valid", lookup_valid, 1);
    chk("lk0_id", lookup_id, 0);
    chk("lk0_addr", lookup_addr, 32'h1000);
    chk("lk0_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("lk1_id", lookup_id, 0);
    chk("lk1_addr", lookup_addr, 32'h1000);
    chk("lk1_ready", req_ready, 0);
    @(negedge clk);
    flush_req = 1;
    #1;
    chk("lk2_id", lookup_id, 0);
    chk("lk2_valid", lookup_valid, 1);
    @(negedge clk);
    flush_req = 0; lookup_ready = 1;
    #1;
    chk("acc_busy", busy, 0);
    chk("acc_ready", req_ready, 2'b01);
    chk("acc_id", lookup_id, 0);
    chk("acc_addr", lookup_addr, 32'h1000);
    @(negedge clk);
    #1;
    chk("next_id", lookup_id, 1);
    chk("next_ready", req_ready, 2'b10);
    chk("next_addr", lookup_addr, 32'h2000);
    @(negedge clk);
    #1;
    chk("cap_valid", lookup_valid, 0);
    chk("cap_ready", req_ready, 0);
    @(negedge clk);
    rsp_done = 1;
    #1 chk("cap_valid_done", lookup_valid, 0);
    @(negedge clk);
    rsp_done = 0;
    #1;
    chk("cap_regrant", lookup_valid, 1);
    chk("cap_regrant_id", lookup_id, 0);
    @(negedge clk);
    rsp_done = 1;
    #1 chk("cap_full", lookup_valid, 0);
    @(negedge clk);
    #1;
    chk("sim_valid", lookup_valid, 1);
    chk("sim_id", lookup_id, 1);
    @(negedge clk);
    rsp_done = 0;
    #1;
    chk("sim_fill", lookup_valid, 1);
    chk("sim_fill_id", lookup_id, 0);
    @(negedge clk);
    #1 chk("sim_blocked", lookup_valid, 0);
    flush_req = 1;
    #1 chk("fl_req_valid", lookup_valid, 0);
    @(negedge clk);
    flush_req = 0; rsp_done = 1;
    #1;
    chk("drain_busy", busy, 1);
    chk("drain_valid", lookup_valid, 0);
    chk("drain_fv", flush_valid, 0);
    @(negedge clk);
    #1 chk("drain_fv1", flush_valid, 0);
    @(negedge clk);
    rsp_done = 0;
    @(negedge clk);
    #1;
    chk("flush_fv", flush_valid, 1);
    chk("flush_lv", lookup_valid, 0);
    @(negedge clk);
    flush_ready = 1; req_valid = 0;
    #1 chk("flush_fv_hold", flush_valid, 1);
    @(negedge clk);
    flush_ready = 0;
    #1;
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); #1; end
    chk("flush_sweep_len", n, 129);
    flush_req = 1;
    #1 chk("fs_run", busy, 0);
    @(negedge clk);
    flush_req = 0;
    #1;
    n = 0;
    while (!flush_valid && n < 10) begin n++; @(negedge clk); #1; end
    chk("fs_first_fv", flush_valid, 1);
    flush_ready = 1;
    @(negedge clk);
    flush_ready = 0;
    #1;
    n = 0; brk = 0;
    while (!flush_valid && n < 300) begin
      brk |= !busy;
      flush_req = (n == 10);
      @(negedge clk);
      #1;
      n++;
    end
    flush_req = 0;
    chk("fs_fv_at", n, 130);
    chk("fs_busy_cont", brk, 0);
    flush_ready = 1;
    @(negedge clk);
    flush_ready = 0;
    #1;
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); #1; end
    chk("fs_sweep2_len", n, 129);
    req_addr = {32'h0000_4000, 32'h0000_3000}; req_valid = 2'b01; lookup_ready = 0;
    #1 chk("rm_valid", lookup_valid, 1);
    @(negedge clk);
    #1 chk("rm_lock_addr", lookup_addr, 32'h3000);
    rst = 1;
    #1;
    chk("rm_busy", busy, 1);
    chk("rm_valid_drop", lookup_valid, 0);
    chk("rm_ready", req_ready, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rm_after_busy", busy, 1);
    chk("rm_after_valid", lookup_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
